// File: rtl/bias_loader.sv
// bias_loader: write-side front end for the per-layer bias memory.
// Bias words arrive one at a time over a valid/ready stream. They are
// gathered into a staging array of NUM_WORDS words, and the complete array
// is then committed with a single active-low write strobe. The bias memory
// never sees a partial set committed.
//
// Handshake: a word transfers on a posedge where in_valid && in_ready.
// in_ready is registered and depends only on the current state. It does not
// depend on in_valid. in_valid may drop for any number of cycles, and
// in_data only has to be stable while in_valid is high.
module bias_loader #(
  parameter int NUM_FEATURES = 3,
  parameter int DATA_WIDTH   = 32,
  localparam int NUM_WORDS   = NUM_FEATURES + 1,
  localparam int WC_W        = $clog2(NUM_WORDS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         load_abort,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         bias_WrEn,
  output logic signed [DATA_WIDTH-1:0] bias_weights_input [NUM_WORDS],
  output logic                         busy,
  output logic                         done,
  output logic [WC_W-1:0]              word_count,
  output logic [1:0]                   o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t                       r_state;
  logic                         r_in_ready;
  logic                         r_wr_en_n;
  logic                         r_busy;
  logic                         r_done;
  logic [WC_W-1:0]              r_word_count;
  logic signed [DATA_WIDTH-1:0] r_staging [NUM_WORDS];

  logic                         w_xfer;
  logic                         w_last;

  assign w_xfer = in_valid && r_in_ready;
  assign w_last = (r_word_count == WC_W'(NUM_WORDS - 1));

  // Control FSM. The outputs are registered alongside the state, so that
  // each output is a pure function of the registered state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_wr_en_n    <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state      <= S_COLLECT;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_word_count <= '0;
          end
        end
        S_COLLECT: begin
          // Abort wins over a simultaneous transfer, and that word is dropped.
          if (load_abort) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_word_count <= '0;
          end else if (w_xfer) begin
            r_word_count <= r_word_count + 1'b1;
            if (w_last) begin
              r_state    <= S_COMMIT;
              r_in_ready <= 1'b0;
              r_wr_en_n  <= 1'b0;
            end
          end
        end
        S_COMMIT: begin
          // The strobe lasts exactly one cycle. Abort and start are ignored here.
          r_state      <= S_IDLE;
          r_wr_en_n    <= 1'b1;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
          r_word_count <= '0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_wr_en_n  <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Staging array. A word changes only on an accepted transfer, so the array
  // holds steady through IDLE and through the commit cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_staging[i] <= '0;
      end
    end else if ((r_state == S_COLLECT) && !load_abort && w_xfer) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (r_word_count == WC_W'(i)) begin
          r_staging[i] <= in_data;
        end
      end
    end
  end

  // Drive the staging array out to the bias memory data input.
  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      bias_weights_input[i] = r_staging[i];
    end
  end

  assign in_ready    = r_in_ready;
  assign bias_WrEn   = r_wr_en_n;
  assign busy        = r_busy;
  assign done        = r_done;
  assign word_count  = r_word_count;
  assign o_dbg_state = r_state;

endmodule

// File: doc/bias_loader.md
Name: bias_loader

Overview:
- Write-side front end for the per-layer bias memory.
- Accepts bias words one at a time over a valid/ready stream, typically from the off-chip weight fetch path.
- Assembles them into a staging array of NUM_FEATURES+1 words, then commits the whole array with a single active-low write strobe.
- Writes only whole, consistent sets. A partial set is never exposed to the bias memory's write port as committed.

Parameters:
- NUM_FEATURES, 3: number of feature biases. Total words NUM_WORDS = NUM_FEATURES+1 (index 0 is the extra/shared bias). Must match the bias memory instance.
- DATA_WIDTH, 32: bias word width, signed two's complement.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- load_start  input  1  begins a load when in IDLE; ignored otherwise.
- load_abort  input  1  abandons a load in COLLECT; no commit.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_WIDTH (signed)  bias word, in index order 0..NUM_WORDS-1.
- in_ready  output  1  block accepts in_data this cycle.
- bias_WrEn  output  1  write enable to the bias memory, active-low.
- bias_weights_input  output  DATA_WIDTH (signed) x NUM_WORDS  staging array, wired to the bias memory data input.
- busy  output  1  high in COLLECT and COMMIT.
- done  output  1  one-cycle pulse after a successful commit.
- word_count  output  $clog2(NUM_WORDS+1)  number of words accepted in the current load.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, bias_WrEn=1, in_ready=0, busy=0, done=0, word_count=0.
  - All staging words = 0.
  - Reset during COLLECT or COMMIT discards the load; no write strobe is produced.
- All outputs are registered. in_ready, busy and bias_WrEn are decoded from registered state only.
- IDLE:
  - in_ready=0, busy=0, bias_WrEn=1.
  - load_start=1 at a posedge -> COLLECT and word_count<=0.
  - Staging contents are retained, not cleared.
- COLLECT:
  - in_ready=1, busy=1.
  - Transfer occurs when in_valid && in_ready at a posedge: staging[word_count]<=in_data, word_count<=word_count+1.
  - When the transfer is word NUM_WORDS-1: state<=COMMIT and bias_WrEn<=0 at the same edge.
  - load_abort=1 -> IDLE, word_count<=0, no commit. load_abort has priority over a simultaneous transfer; that word is dropped.
  - load_start in COLLECT is ignored.
- COMMIT (exactly one cycle):
  - in_ready=0, busy=1, bias_WrEn=0.
  - The staging array is complete and stable for the whole cycle, so the bias memory's negedge capture sees all NUM_WORDS words.
  - Next posedge: state<=IDLE, bias_WrEn<=1, done<=1, word_count<=0. load_abort is ignored in COMMIT.
- done is high for exactly one cycle, the first IDLE cycle after COMMIT. A load_start in that same cycle is honoured.
- Latency:
  - load_start sampled at edge k -> in_ready high from edge k onward.
  - Minimum load is NUM_WORDS+1 cycles from the first transfer to the done pulse.
- Staging words change only on a transfer, never in IDLE or COMMIT, so bias_weights_input is glitch-free while bias_WrEn is high.
- No arithmetic; in_data is stored bit-exact. in_valid stalls (gaps) of any length are tolerated.

Test Plan:
- Basic load (NUM_FEATURES=3)
  - Stimulus: after reset, load_start, then stream 10, -5, 0x7FFFFFFF, 0x80000000 back-to-back.
  - Response: bias_WrEn low for exactly one cycle after the 4th transfer. bias_weights_input={10,-5,0x7FFFFFFF,0x80000000} during that cycle. done pulses on the next cycle. Bias memory readback matches.
- Stalled stream
  - Stimulus: same words with in_valid gaps of 0, 3 and 7 cycles.
  - Response: identical array committed. word_count steps 0..4. No early bias_WrEn low.
- Abort
  - Stimulus: load_start, 2 words (1, 2), then load_abort together with a valid 3.
  - Response: IDLE, word_count=0, bias_WrEn stays 1, done stays 0. Staging[0..1]={1,2}; staging[2] unchanged.
- Reset mid-collect
  - Stimulus: drop rst after 3 of 4 words.
  - Response: all outputs at reset values immediately (asynchronous). No write strobe. Memory reads all zeros.
- Back-to-back loads
  - Stimulus: load_start asserted in the done cycle, then 4 new words.
  - Response: second commit occurs. Exactly two bias_WrEn pulses total. Final memory holds the second set.
- Ignored start
  - Stimulus: load_start pulsed during COLLECT and COMMIT.
  - Response: no state change and no extra commit.
